// File: rtl/status_flag_unit.sv
// Status flag producer: computes {N,Z,C,V} for flag-setting ALU ops, holds them in a
// one-entry pending slot, commits them to the architectural register, and forwards the newest word.
module status_flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_valid,
  input  logic             s_bit,
  input  logic             cond_met,
  input  logic [1:0]       op_class,
  input  logic             use_cin,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             shifter_carry,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       status_q,
  output logic [3:0]       status_fwd,
  output logic             flags_busy
);

  typedef enum logic [1:0] {
    OpLogic  = 2'b00,
    OpAdd    = 2'b01,
    OpSub    = 2'b10,
    OpNoFlag = 2'b11
  } op_class_e;

  logic [3:0]       arch_q, arch_d;
  logic [3:0]       pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [3:0]       fwd;
  logic [3:0]       new_flags;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             cap;
  logic             unused_sum_lo;

  assign fwd = pend_v_q ? pend_q : arch_q;

  // SUB is a + ~b + cin; C=1 means no borrow.
  always_comb begin
    b_eff = op_b;
    cin   = 1'b0;
    unique case (op_class)
      OpAdd:   cin = use_cin ? fwd[1] : 1'b0;
      OpSub: begin
        b_eff = ~op_b;
        cin   = use_cin ? fwd[1] : 1'b1;
      end
      OpLogic, OpNoFlag: cin = 1'b0;
      default: cin = 1'b0;
    endcase
    sum = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  end

  assign unused_sum_lo = ^sum[WIDTH-2:0];

  always_comb begin
    new_flags[3] = alu_result[WIDTH-1];
    new_flags[2] = (alu_result == '0);
    if (op_class == OpLogic) begin
      new_flags[1] = shifter_carry;
      new_flags[0] = fwd[0];
    end else begin
      new_flags[1] = sum[WIDTH];
      new_flags[0] = (op_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
    end
  end

  assign cap = exe_valid & s_bit & cond_met & (op_class != OpNoFlag) & ~stall & ~flush;

  always_comb begin
    arch_d   = arch_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (flush) begin
      pend_v_d = 1'b0;
    end else if (!stall) begin
      if (pend_v_q) arch_d = pend_q;
      pend_d   = new_flags;
      pend_v_d = cap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arch_q   <= 4'b0000;
      pend_q   <= 4'b0000;
      pend_v_q <= 1'b0;
    end else begin
      arch_q   <= arch_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign status_q   = arch_q;
  assign status_fwd = fwd;
  assign flags_busy = pend_v_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed vector table, a hand-written stall/chain sequence,
// and randomized traffic checked against a signed-arithmetic reference model.
module tb_status_flag_unit;

  logic        clk = 1'b0;
  logic        rst, exe_valid, s_bit, cond_met, use_cin, shifter_carry, stall, flush;
  logic [1:0]  op_class;
  logic [31:0] op_a, op_b, alu_result;
  logic [3:0]  status_q, status_fwd;
  logic        flags_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  status_flag_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_valid    (exe_valid),
    .s_bit        (s_bit),
    .cond_met     (cond_met),
    .op_class     (op_class),
    .use_cin      (use_cin),
    .op_a         (op_a),
    .op_b         (op_b),
    .alu_result   (alu_result),
    .shifter_carry(shifter_carry),
    .stall        (stall),
    .flush        (flush),
    .status_q     (status_q),
    .status_fwd   (status_fwd),
    .flags_busy   (flags_busy)
  );

  typedef struct {
    logic        rst, ev, s, cm;
    logic [1:0]  opc;
    logic        uc;
    logic [31:0] a, b, r;
    logic        sc, st, fl;
    logic [3:0]  eq, ef;
    logic        eb;
  } vec_t;

  function automatic vec_t mk(input logic rst_v, ev, s, cm, input logic [1:0] opc,
                              input logic uc, input logic [31:0] a, b, r,
                              input logic sc, st, fl, input logic [3:0] eq, ef,
                              input logic eb);
    vec_t v;
    v.rst = rst_v; v.ev = ev; v.s = s; v.cm = cm; v.opc = opc; v.uc = uc;
    v.a = a; v.b = b; v.r = r; v.sc = sc; v.st = st; v.fl = fl;
    v.eq = eq; v.ef = ef; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; exe_valid = v.ev; s_bit = v.s; cond_met = v.cm; op_class = v.opc;
    use_cin = v.uc; op_a = v.a; op_b = v.b; alu_result = v.r; shifter_carry = v.sc;
    stall = v.st; flush = v.fl;
  endtask

  task automatic apply_check(input string tag, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check($sformatf("%s status_q", tag), status_q, v.eq);
    check($sformatf("%s status_fwd", tag), status_fwd, v.ef);
    check($sformatf("%s flags_busy", tag), {3'b000, flags_busy}, {3'b000, v.eb});
  endtask

  // Reference model: flags from signed/unsigned integer arithmetic.
  logic [3:0] m_arch, m_pend;
  logic       m_pv;

  function automatic logic [3:0] ref_flags(input logic [1:0] opc, input logic uc,
                                           input logic [31:0] a, b, r, input logic sc,
                                           input logic [3:0] fwd);
    longint          sa, sb, sr;
    longint unsigned ua, ub;
    logic            c, v, ci;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    c  = 1'b0;
    v  = 1'b0;
    case (opc)
      2'b00: begin c = sc; v = fwd[0]; end
      2'b01: begin
        ci = uc ? fwd[1] : 1'b0;
        c  = (ua + ub + longint'(ci)) >= 64'h1_0000_0000;
        sr = sa + sb + longint'(ci);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b10: begin
        ci = uc ? fwd[1] : 1'b1;
        c  = (ua + longint'(ci)) >= (ub + 1);
        sr = sa - sb - 1 + longint'(ci);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: ;
    endcase
    return {r[31], r == 32'd0, c, v};
  endfunction

  function automatic logic [31:0] pick_val();
    logic [31:0] vals[6];
    vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'h7FFF_FFFF;
    vals[3] = 32'h8000_0000; vals[4] = 32'hFFFF_FFFF; vals[5] = $urandom;
    return ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
  endfunction

  vec_t tbl[24];

  initial begin
    //          rst ev s  cm opc  uc a             b             r             sc st fl eq     ef     eb
    tbl[0]  = mk(1, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0, 0, 4'h0, 4'h0, 0);
    tbl[1]  = mk(1, 1, 1, 1, 2'd2, 1, 32'h5,        32'h9,        32'h0,        1, 1, 1, 4'h0, 4'h0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 0, 4'h0, 4'h9, 1);
    tbl[3]  = mk(0, 0, 0, 0, 2'd3, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 4'h9, 4'h9, 0);
    tbl[4]  = mk(0, 1, 1, 1, 2'd2, 0, 32'h5,        32'h5,        32'h0,        0, 0, 0, 4'h9, 4'h6, 1);
    tbl[5]  = mk(0, 1, 1, 1, 2'd0, 0, 32'h0,        32'h0,        32'h80000000, 0, 0, 0, 4'h6, 4'h8, 1);
    tbl[6]  = mk(0, 0, 0, 0, 2'd3, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 4'h8, 4'h8, 0);
    tbl[7]  = mk(0, 1, 1, 1, 2'd2, 0, 32'h5,        32'h5,        32'h0,        0, 0, 0, 4'h8, 4'h6, 1);
    tbl[8]  = mk(0, 1, 1, 1, 2'd1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 0, 4'h6, 4'h6, 1);
    tbl[9]  = mk(0, 1, 1, 1, 2'd0, 0, 32'h0,        32'h0,        32'h1,        0, 0, 0, 4'h6, 4'h0, 1);
    tbl[10] = mk(0, 1, 1, 1, 2'd2, 1, 32'h3,        32'h3,        32'hFFFFFFFF, 0, 0, 0, 4'h0, 4'h8, 1);
    tbl[11] = mk(0, 1, 1, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h2,        32'h1,        0, 0, 0, 4'h8, 4'h2, 1);
    tbl[12] = mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 4'h8, 4'h2, 1);
    tbl[13] = mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 4'h8, 4'h2, 1);
    tbl[14] = mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 4'h8, 4'h2, 1);
    tbl[15] = mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 1, 4'h8, 4'h8, 0);
    tbl[16] = mk(0, 1, 1, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h2,        32'h1,        0, 0, 0, 4'h8, 4'h2, 1);
    tbl[17] = mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 1, 4'h8, 4'h8, 0);
    tbl[18] = mk(0, 1, 0, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 4'h8, 4'h8, 0);
    tbl[19] = mk(0, 1, 1, 0, 2'd1, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 4'h8, 4'h8, 0);
    tbl[20] = mk(0, 1, 1, 1, 2'd3, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 4'h8, 4'h8, 0);
    tbl[21] = mk(0, 0, 1, 1, 2'd0, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 4'h8, 4'h8, 0);
    tbl[22] = mk(0, 1, 1, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h2,        32'h1,        0, 0, 0, 4'h8, 4'h2, 1);
    tbl[23] = mk(1, 1, 1, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h2,        32'h1,        0, 1, 0, 4'h0, 4'h0, 0);

    drive(tbl[0]);
    for (int i = 0; i < 24; i++) apply_check($sformatf("vec%0d", i), tbl[i]);

    // Capture with V=1, stall, then a LOGIC op chains V from the still-pending word.
    apply_check("seq reset", mk(1, 0, 0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    apply_check("seq add",   mk(0, 1, 1, 1, 2'd1, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000,
                                0, 0, 0, 4'h0, 4'h9, 1));
    apply_check("seq stall", mk(0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 1, 1, 0, 4'h0, 4'h9, 1));
    apply_check("seq logic", mk(0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 1, 0, 0, 4'h9, 4'h7, 1));
    apply_check("seq drain", mk(0, 0, 0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 4'h7, 4'h7, 0));

    // Randomized traffic against the reference model.
    m_arch = 4'h0; m_pend = 4'h0; m_pv = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] m_fwd, nf;
      logic       m_cap;
      rst           = ($urandom_range(0, 49) == 0);
      exe_valid     = ($urandom_range(0, 7) != 0);
      s_bit         = ($urandom_range(0, 5) != 0);
      cond_met      = ($urandom_range(0, 5) != 0);
      op_class      = 2'($urandom_range(0, 3));
      use_cin       = $urandom_range(0, 1) == 1;
      op_a          = pick_val();
      op_b          = pick_val();
      alu_result    = ($urandom_range(0, 3) == 0) ? 32'h0 : pick_val();
      shifter_carry = $urandom_range(0, 1) == 1;
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      m_fwd = m_pv ? m_pend : m_arch;
      nf    = ref_flags(op_class, use_cin, op_a, op_b, alu_result, shifter_carry, m_fwd);
      m_cap = exe_valid && s_bit && cond_met && op_class != 2'd3;
      if (rst) begin
        m_arch = 4'h0; m_pend = 4'h0; m_pv = 1'b0;
      end else if (flush) begin
        m_pv = 1'b0;
      end else if (!stall) begin
        if (m_pv) m_arch = m_pend;
        if (m_cap) m_pend = nf;
        m_pv = m_cap;
      end
      @(posedge clk);
      #1;
      check($sformatf("rand%0d status_q", i), status_q, m_arch);
      check($sformatf("rand%0d status_fwd", i), status_fwd, m_pv ? m_pend : m_arch);
      check($sformatf("rand%0d flags_busy", i), {3'b000, flags_busy}, {3'b000, m_pv});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Producer side of the condition-check interface. Generates the {N,Z,C,V} status word that the condition checker consumes, and maintains it.
- Computes flags for flag-setting (S-bit) ALU instructions in EXE and holds them in a one-entry pending slot (MEM/WB-aligned).
- Commits pending flags to the architectural status register.
- Exports a forwarded status word so the next instruction's condition evaluation sees the newest flags without waiting for commit.

Parameters:
- WIDTH, 32, datapath width of operands and ALU result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- exe_valid  in  1  EXE stage holds a real instruction.
- s_bit  in  1  instruction requests flag update.
- cond_met  in  1  instruction's condition passed.
- op_class  in  2  00 LOGIC, 01 ADD, 10 SUB, 11 NOFLAG.
- use_cin  in  1  ADC/SBC: carry-in taken from status_fwd.C.
- op_a  in  WIDTH  first ALU operand.
- op_b  in  WIDTH  second ALU operand, post-shifter.
- alu_result  in  WIDTH  ALU result; N/Z source.
- shifter_carry  in  1  shifter carry-out, used as C for LOGIC.
- stall  in  1  pipeline hold.
- flush  in  1  kill EXE instruction and pending slot.
- status_q  out  4  architectural {N,Z,C,V}.
- status_fwd  out  4  newest {N,Z,C,V}: pending if valid, else architectural.
- flags_busy  out  1  pending slot valid.

Behaviour:
- Bit order everywhere is {N,Z,C,V}: N=bit3, V=bit0.
- **State:**
  - arch[3:0]
  - pend[3:0]
  - pend_v
- **Reset (rst=1 at edge):** arch=0, pend=0, pend_v=0. Therefore status_q=0, status_fwd=0, flags_busy=0. Reset overrides stall/flush and is valid mid-operation.
- **Outputs:** status_q=arch; status_fwd = pend_v ? pend : arch (combinational); flags_busy=pend_v.
- **Capture enable:** cap = exe_valid & s_bit & cond_met & (op_class!=11) & ~stall & ~flush.
- **New flags (combinational):**
  - All classes: N = alu_result[WIDTH-1]; Z = (alu_result==0).
  - LOGIC: C = shifter_carry; V = status_fwd.V (unchanged).
  - ADD:
    - Carry-in: cin = use_cin ? status_fwd.C : 0.
    - Sum: {C,s} = op_a + op_b + cin, computed at WIDTH+1 bits.
    - Overflow: V = (op_a[msb]==op_b[msb]) & (s[msb]!=op_a[msb]).
  - SUB:
    - Carry-in: cin = use_cin ? status_fwd.C : 1.
    - Sum: {C,s} = op_a + ~op_b + cin. C=1 means no borrow.
    - Overflow: V = (op_a[msb]!=op_b[msb]) & (s[msb]!=op_a[msb]).
  - Internal s is used only for C/V. N/Z always come from alu_result.
- **Sequential update (rst=0):**
  - If flush: pend_v<=0; arch unchanged; pending flags discarded; no capture.
  - Else if stall: all state holds.
  - Else:
    - If pend_v, arch<=pend (commit).
    - pend<=new flags and pend_v<=cap.
    - Commit and capture in the same cycle are legal: the old pend goes to arch and the new flags go to pend.
- **Latency:**
  - An instruction captured at edge k is visible on status_fwd after edge k.
  - It is visible on status_q after the first later non-stalled, non-flushed edge.
- **Chaining:** back-to-back flag setters chain correctly because LOGIC V and ADC/SBC cin read status_fwd, i.e. the previous pending value.
- **Flush and stall asserted together:** flush wins.
- **Non-capturing instructions:** cond_met=0, s_bit=0 or NOFLAG never modify flags, but still allow a pending commit.
- **Arithmetic:** all arithmetic is unsigned modulo 2^WIDTH; no X-propagation paths; no latches.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> status_q=0000, status_fwd=0000, flags_busy=0.
- ADD overflow: ADD, op_a=0x7FFFFFFF, op_b=1, alu_result=0x80000000, s_bit=1 -> after edge k status_fwd=1001, status_q=0000; after edge k+1 status_q=1001, flags_busy=0.
- SUB equal then chained logic:
  - SUB 5-5, alu_result=0 -> status_fwd=0110.
  - Next cycle LOGIC, alu_result=0x80000000, shifter_carry=0 -> status_fwd=1000 (V kept 0).
  - Then status_q=1000.
- ADC chain: status_fwd.C=1, ADD use_cin=1, op_a=0xFFFFFFFF, op_b=0, alu_result=0 -> fwd=0110. SBC with C=0, op_a=op_b=3, alu_result=0xFFFFFFFF -> fwd=1000.
- Stall/flush:
  - Capture ADD.
  - Assert stall 3 cycles -> status_fwd and flags_busy unchanged, status_q not updated.
  - Then flush -> flags_busy=0, status_fwd=status_q=prior arch.
  - flush+stall together -> flush wins.
- Gating: s_bit=0, cond_met=0, op_class=11 each with flag-changing operands -> status_fwd/status_q unchanged, flags_busy=0.
